// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// ALU function codes, immediate formats and datapath select codes.
package ctrl_defs;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR      = 4'd11;
  localparam logic [3:0] S_LUI       = 4'd12;
  localparam logic [3:0] S_HALT      = 4'd13;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RD1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Which ALU operation family the current state asks for.
  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_FUNCT = 2'd2
  } alu_cls_e;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU function decoder: fixed add/sub, or funct3/funct7 decode
// for register and immediate arithmetic.
module alu_decoder
  import ctrl_defs::*;
(
  input  alu_cls_e   cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [2:0] func
);

  always_comb begin
    func = ALU_ADD;
    case (cls)
      ALU_CLS_SUB: func = ALU_SUB;
      ALU_CLS_FUNCT: begin
        case (funct3)
          3'b000:  func = (op5 && funct7_5) ? ALU_SUB : ALU_ADD; // addi never subtracts
          3'b010:  func = ALU_SLT;
          3'b100:  func = ALU_XOR;
          3'b110:  func = ALU_OR;
          3'b111:  func = ALU_AND;
          default: func = ALU_ADD;
        endcase
      end
      default: func = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (fetch/decode/execute/memory/writeback).
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in HALT with illegal=1.
module multicycle_controller
  import ctrl_defs::*;
#(
  parameter logic [3:0] RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] ALU_src_a,
  output logic [1:0] ALU_src_b,
  output logic [2:0] ALU_func,
  output logic [2:0] imm_src,
  output logic       illegal
);

  logic [3:0] state;
  logic [3:0] state_next;
  alu_cls_e   alu_cls;
  logic [2:0] alu_func_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESET_STATE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:     if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           state_next = S_HALT;
`else
          default:           state_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR:   state_next = (op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
      S_EXEC_R:    state_next = S_ALU_WB;
      S_EXEC_I:    state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JALR:      state_next = S_JAL;
      S_JAL:       state_next = S_ALU_WB;
      S_LUI:       state_next = S_ALU_WB;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:      state_next = S_HALT;
`endif
      // Unused or unknown encodings fall back to fetch.
      default:     state_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .cls      (alu_cls),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .op5      (op[5]),
    .func     (alu_func_dec)
  );

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALU_OUT;
    ALU_src_a  = SRCA_PC;
    ALU_src_b  = SRCB_RD2;
    alu_cls    = ALU_CLS_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        result_src = RES_ALU;
        ALU_src_b  = SRCB_FOUR;
      end
      S_DECODE: begin
        ALU_src_a = SRCA_OLD_PC;
        ALU_src_b = SRCB_IMM;
      end
      S_MEM_ADR, S_JALR: begin
        ALU_src_a = SRCA_RD1;
        ALU_src_b = SRCB_IMM;
      end
      S_MEM_READ:  adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ALU_src_a = SRCA_RD1;
        alu_cls   = ALU_CLS_FUNCT;
      end
      S_EXEC_I: begin
        ALU_src_a = SRCA_RD1;
        ALU_src_b = SRCB_IMM;
        alu_cls   = ALU_CLS_FUNCT;
      end
      S_ALU_WB:    reg_write = 1'b1;
      S_BRANCH: begin
        ALU_src_a = SRCA_RD1;
        alu_cls   = ALU_CLS_SUB;
        pc_write  = (funct3[2:1] == 2'b00) && (zero ^ funct3[0]);
      end
      S_JAL: begin
        ALU_src_a = SRCA_OLD_PC;
        ALU_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        ALU_src_a = SRCA_ZERO;
        ALU_src_b = SRCB_IMM;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT:      illegal = 1'b1;
`endif
      default: ;
    endcase

    ALU_func = alu_func_dec;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      OP_LUI:    imm_src = IMM_U;
      default:   imm_src = IMM_I;
    endcase

    // Reset forces every output low without waiting for the state register.
    if (!rst) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      ALU_src_a  = 2'b00;
      ALU_src_b  = 2'b00;
      ALU_func   = 3'b000;
      imm_src    = 3'b000;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller; honours ILLEGAL_TRAP_EN when defined.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, ALU_src_a, ALU_src_b;
  logic [2:0] ALU_func, imm_src;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .ALU_src_a  (ALU_src_a),
    .ALU_src_b  (ALU_src_b),
    .ALU_func   (ALU_func),
    .imm_src    (imm_src),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                ALU_src_a, ALU_src_b, ALU_func, imm_src, illegal};

  int          n_chk = 0;
  int          n_fail = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (pcw adr irw mw rw rs a b fn imm ill)", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ctl(input logic pcw, input logic adr, input logic irw,
                                      input logic mw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] fn, input logic [2:0] im,
                                      input logic ill);
    return {pcw, adr, irw, mw, rw, rs, sa, sb, fn, im, ill};
  endfunction

  function automatic logic [17:0] fetch_v(input logic rdy, input logic [2:0] im);
    return ctl(rdy, 1'b0, rdy, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, im, 1'b0);
  endfunction

  function automatic logic [17:0] dec_v(input logic [2:0] im);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, im, 1'b0);
  endfunction

  function automatic logic [17:0] wb_v(input logic [2:0] im);
    return ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, im, 1'b0);
  endfunction

  // Caller sits 1 time unit after a rising edge; returns at the same point one cycle later.
  task automatic step(input string tag, input logic mr, input logic [17:0] e);
    mem_ready = mr;
    exp_q.push_back(e);
    #2;
    chk(tag, obs, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75);
    op = o;
    funct3 = f3;
    funct7_5 = f75;
  endtask

  logic [2:0] r_f3 [6] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b001};
  logic [2:0] r_fn [6] = '{3'b000, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000};
  logic [2:0] br_f3 [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
  logic       br_z  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       br_pc [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs low even with mem_ready high.
    mem_ready = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", obs, 18'd0);
    rst = 1'b1;

    // R-type funct3 sweep, f7_5=0
    for (int i = 0; i < 6; i++) begin
      set_instr(7'b0110011, r_f3[i], 1'b0);
      step("r_fetch", 1'b1, fetch_v(1'b1, 3'b000));
      step("r_decode", 1'b1, dec_v(3'b000));
      step("r_exec", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, r_fn[i], 3'b000, 0));
      step("r_wb", 1'b1, wb_v(3'b000));
    end

    // sub
    set_instr(7'b0110011, 3'b000, 1'b1);
    step("sub_fetch", 1'b1, fetch_v(1'b1, 3'b000));
    step("sub_decode", 1'b1, dec_v(3'b000));
    step("sub_exec", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
    step("sub_wb", 1'b1, wb_v(3'b000));

    // addi with bit 30 set stays add; xori
    set_instr(7'b0010011, 3'b000, 1'b1);
    step("addi_fetch", 1'b1, fetch_v(1'b1, 3'b000));
    step("addi_decode", 1'b1, dec_v(3'b000));
    step("addi_exec", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    step("addi_wb", 1'b1, wb_v(3'b000));
    set_instr(7'b0010011, 3'b100, 1'b0);
    step("xori_fetch", 1'b1, fetch_v(1'b1, 3'b000));
    step("xori_decode", 1'b1, dec_v(3'b000));
    step("xori_exec", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b100, 3'b000, 0));
    step("xori_wb", 1'b1, wb_v(3'b000));

    // lw: 2 fetch waits, 3 read waits; writeback lands in cycle 10
    set_instr(7'b0000011, 3'b010, 1'b0);
    step("lw_fetch_wait", 1'b0, fetch_v(1'b0, 3'b000));
    step("lw_fetch_wait", 1'b0, fetch_v(1'b0, 3'b000));
    step("lw_fetch_rdy", 1'b1, fetch_v(1'b1, 3'b000));
    step("lw_decode", 1'b1, dec_v(3'b000));
    step("lw_memadr", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    for (int i = 0; i < 3; i++)
      step("lw_read_wait", 1'b0, ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    step("lw_read_rdy", 1'b1, ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    step("lw_memwb", 1'b1, ctl(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));

    // beq / bne / blt
    for (int i = 0; i < 5; i++) begin
      set_instr(7'b1100011, br_f3[i], 1'b0);
      zero = br_z[i];
      step("br_fetch", 1'b1, fetch_v(1'b1, 3'b010));
      step("br_decode", 1'b1, dec_v(3'b010));
      step("br_branch", 1'b1, ctl(br_pc[i], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));
    end
    zero = 1'b0;

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    step("jal_fetch", 1'b1, fetch_v(1'b1, 3'b011));
    step("jal_decode", 1'b1, dec_v(3'b011));
    step("jal_jal", 1'b1, ctl(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0));
    step("jal_wb", 1'b1, wb_v(3'b011));

    // jalr
    set_instr(7'b1100111, 3'b000, 1'b0);
    step("jalr_fetch", 1'b1, fetch_v(1'b1, 3'b000));
    step("jalr_decode", 1'b1, dec_v(3'b000));
    step("jalr_target", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    step("jalr_jal", 1'b1, ctl(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0));
    step("jalr_wb", 1'b1, wb_v(3'b000));

    // lui
    set_instr(7'b0110111, 3'b000, 1'b0);
    step("lui_fetch", 1'b1, fetch_v(1'b1, 3'b100));
    step("lui_decode", 1'b1, dec_v(3'b100));
    step("lui_exec", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 3'b100, 0));
    step("lui_wb", 1'b1, wb_v(3'b100));

    // sw with one write wait
    set_instr(7'b0100011, 3'b010, 1'b0);
    step("sw_fetch", 1'b1, fetch_v(1'b1, 3'b001));
    step("sw_decode", 1'b1, dec_v(3'b001));
    step("sw_memadr", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
    step("sw_write_wait", 1'b0, ctl(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
    step("sw_write_rdy", 1'b1, ctl(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));

    // sw interrupted by reset mid-cycle
    step("swr_fetch", 1'b1, fetch_v(1'b1, 3'b001));
    step("swr_decode", 1'b1, dec_v(3'b001));
    step("swr_memadr", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
    mem_ready = 1'b0;
    #2;
    chk("swr_write_pre", obs, ctl(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
    rst = 1'b0;
    #1;
    chk("swr_async_mem_write", {17'd0, mem_write}, 18'd0);
    chk("swr_async_all", obs, 18'd0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("swr_after_release", 1'b0, fetch_v(1'b0, 3'b001));

    // unknown opcode
    set_instr(7'b1111111, 3'b000, 1'b0);
    step("ill_fetch", 1'b1, fetch_v(1'b1, 3'b000));
    step("ill_decode", 1'b1, dec_v(3'b000));
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++)
      step("ill_halt", 1'b1, ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1));
    mem_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("ill_reset_clears", obs, 18'd0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_instr(7'b0110011, 3'b000, 1'b0);
    step("ill_refetch", 1'b1, fetch_v(1'b1, 3'b000));
`else
    step("ill_back_fetch", 1'b1, fetch_v(1'b1, 3'b000));
    step("ill_decode2", 1'b1, dec_v(3'b000));
    step("ill_back_fetch2", 1'b0, fetch_v(1'b0, 3'b000));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
